store_buffer_controller: RTL and testbench
==========================================

// Module: store_buffer_controller
// PURPOSE
//  Stage-4 store buffer and data-memory write sequencer. Accepts pre-aligned stores
//  (word-replicated data plus 4-bit byte mask) from the memory stage and queues them
//  in a DEPTH-entry FIFO. Drains entries one at a time to the data memory write port
//  over a req/ack handshake; stalls the pipeline when full. Flags loads that hit a
//  pending store, and drains the buffer for fences.
// PARAMETERS
//  DEPTH   4   number of buffered stores; power of two, >=2
//  AW      32  byte-address width; the word address is addr[AW-1:2]
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  st_valid     in   1   store presented this cycle
//  st_addr      in   AW  store byte address
//  st_data      in   32  store data, already replicated into its byte lanes
//  st_mask      in   4   byte-lane write enables (0001/0010/0100/1000, 0011/1100, 1111)
//  st_ready     out  1   store accepted this cycle when st_valid&&st_ready
//  ld_valid     in   1   load in stage 4 this cycle
//  ld_addr      in   AW  load byte address
//  ld_conflict  out  1   load overlaps a buffered store; pipeline must stall the load
//  fence_req    in   1   request to drain the buffer
//  fence_done   out  1   buffer empty while fence_req high
//  mem_req      out  1   write request to data memory
//  mem_addr     out  AW  head-entry address, low two bits forced to 0
//  mem_data     out  32  head-entry data
//  mem_mask     out  4   head-entry byte enables
//  mem_ack      in   1   memory accepted the head entry this cycle
//  count        out  $clog2(DEPTH)+1  number of occupied entries
// BEHAVIOUR
//  - Reset: all entries invalid, head=tail=0, count=0. Outputs: mem_req=0, mem_addr/
//    data/mask=0, st_ready=1, ld_conflict=0, fence_done=0. Reset mid-drain discards
//    every entry, including an unacknowledged head.
//  - Storage: circular FIFO. head/tail pointers are $clog2(DEPTH) bits and wrap
//    modulo DEPTH. count is registered.
//  - Enqueue on st_valid&&st_ready: write to tail, then tail+1. st_ready = (count<DEPTH),
//    except where STORE_MERGE_EN overrides it. A full buffer does not accept a store in
//    the same cycle as mem_ack (no bypass).
//  - Drain: mem_req = (count!=0). mem_addr/data/mask are driven combinationally from
//    the head entry and stay stable while mem_req&&!mem_ack. On mem_ack&&mem_req the
//    head is popped at the clock edge. mem_ack while mem_req=0 is ignored.
//  - Enqueue and pop in the same cycle leave count unchanged. Latency from store
//    accept to mem_req: 1 cycle when the buffer was empty.
//  - Entries drain strictly in order; there is no reordering.
//  - ld_conflict (combinational) = ld_valid && there is a valid entry e with
//    e.addr[AW-1:2]==ld_addr[AW-1:2] && e.mask!=0. The head counts until it is popped.
//    A store accepted in the same cycle is not compared.
//  - fence_done = fence_req && count==0 (combinational). Stores offered during a fence
//    are still accepted normally; the pipeline must withhold them.
//  - Simple two-state view: IDLE (count==0) / DRAIN (count!=0). mem_req==DRAIN.
// CONFIGURATION
//  STORE_MERGE_EN defined:
//  - An incoming store whose word address matches the tail-most entry is merged into
//    that entry. Lanes with st_mask=1 take st_data; mask becomes old|new. tail and
//    count are unchanged.
//  - Merge applies only when count>=2, so the in-flight head is never modified.
//  - On a merge hit, st_ready=1 even when full.
//  STORE_MERGE_EN undefined: every accepted store takes a new entry; no merge logic.
// TESTING
//  1. Reset, then st 0x100/0xAABBCCDD/1111; mem_ack=1 next cycle ->
//     mem_req@+1 with addr 0x100, mask 1111; count 1->0.
//  2. 4 stores, mem_ack=0 -> count=4, st_ready=0. 5th store held; one mem_ack ->
//     5th accepted the following cycle; order preserved across the pointer wrap.
//  3. Buffered st 0x204 mask 0100, ld_addr 0x206 -> ld_conflict=1;
//     ld_addr 0x208 -> 0; after the ack -> 0.
//  4. Enqueue with mem_ack in the same cycle at count=2 -> count stays 2; head
//     advances; new data lands at tail.
//  5. fence_req with 3 entries, ack every cycle -> fence_done rises the cycle count=0.
//     Assert reset mid-drain -> mem_req=0 immediately, count=0.
//  6. STORE_MERGE_EN: entries {0x300 head, 0x310 mask 0001}, then st 0x312 mask 0100 ->
//     merged: count=2, entry mask 0101. The same store with count=1 allocates a new entry.

Source files
------------

// File: rtl/store_buffer_controller.sv
// In-order store buffer: queues aligned stores and drains them to data memory over req/ack.
// Optional macro STORE_MERGE_EN merges a same-word store into the tail-most entry.
module store_buffer_controller #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  input  logic [AW-1:0]          st_addr,
  input  logic [31:0]            st_data,
  input  logic [3:0]             st_mask,
  output logic                   st_ready,
  input  logic                   ld_valid,
  input  logic [AW-1:0]          ld_addr,
  output logic                   ld_conflict,
  input  logic                   fence_req,
  output logic                   fence_done,
  output logic                   mem_req,
  output logic [AW-1:0]          mem_addr,
  output logic [31:0]            mem_data,
  output logic [3:0]             mem_mask,
  input  logic                   mem_ack,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = AW - 2;

  typedef enum logic [0:0] {
    StIdle,
    StDrain
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] waddr_q [DEPTH];
  logic [WW-1:0] waddr_d [DEPTH];
  logic [31:0]   data_q  [DEPTH];
  logic [31:0]   data_d  [DEPTH];
  logic [3:0]    mask_q  [DEPTH];
  logic [3:0]    mask_d  [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] entry_off;
  logic [DEPTH-1:0] entry_valid;
  logic          full;
  logic          pop;
  logic          accept;
  logic          alloc;
`ifdef STORE_MERGE_EN
  logic [PW-1:0] tail_last;
  logic          merge_match;
  logic          merge;
`endif

  // Byte offsets never matter: everything is compared and stored per word.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // Head entry drives the memory port; zeros whenever nothing is pending.
  always_comb begin
    mem_req  = (state_q == StDrain);
    mem_addr = '0;
    mem_data = '0;
    mem_mask = '0;
    if (mem_req) begin
      mem_addr = {waddr_q[head_q], 2'b00};
      mem_data = data_q[head_q];
      mem_mask = mask_q[head_q];
    end
  end

  assign pop = mem_req && mem_ack;

`ifdef STORE_MERGE_EN
  assign tail_last = tail_q - PW'(1);
  // count>=2 keeps the in-flight head out of reach of a merge.
  assign merge_match = (count_q >= CW'(2)) && (waddr_q[tail_last] == st_addr[AW-1:2]);
  assign st_ready    = !full || merge_match;
  assign accept      = st_valid && st_ready;
  assign merge       = accept && merge_match;
  assign alloc       = accept && !merge_match;
`else
  assign st_ready = !full;
  assign accept   = st_valid && st_ready;
  assign alloc    = accept;
`endif

  always_comb begin
    waddr_d = waddr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(alloc) - CW'(pop);
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (alloc) begin
      waddr_d[tail_q] = st_addr[AW-1:2];
      data_d[tail_q]  = st_data;
      mask_d[tail_q]  = st_mask;
      tail_d          = tail_q + PW'(1);
    end
`ifdef STORE_MERGE_EN
    if (merge) begin
      for (int b = 0; b < 4; b++) begin
        if (st_mask[b]) begin
          data_d[tail_last][8*b +: 8] = st_data[8*b +: 8];
        end
      end
      mask_d[tail_last] = mask_q[tail_last] | st_mask;
    end
`endif
  end

  always_comb begin
    state_d = (count_d != '0) ? StDrain : StIdle;
  end

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    entry_off   = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_off      = PW'(i) - head_q;
      entry_valid[i] = ({1'b0, entry_off} < count_q);
    end
  end

  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ld_valid && entry_valid[i] && (waddr_q[i] == ld_addr[AW-1:2]) &&
          (mask_q[i] != 4'b0000)) begin
        ld_conflict = 1'b1;
      end
    end
  end

  assign fence_done = fence_req && (count_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        data_q[i]  <= '0;
        mask_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

endmodule

// File: tb/tb_store_buffer_controller.sv
// Bench for store_buffer_controller: vector table with a scoreboard of drained stores,
// plus hand-written reset-mid-drain and merge sequences.
module tb_store_buffer_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        fence_req;
  logic        fence_done;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_mask;
  logic        mem_ack;
  logic [2:0]  count;

  always #5 clk = ~clk;

  store_buffer_controller #(
    .DEPTH(4),
    .AW   (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_mask    (st_mask),
    .st_ready   (st_ready),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_conflict(ld_conflict),
    .fence_req  (fence_req),
    .fence_done (fence_done),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_mask   (mem_mask),
    .mem_ack    (mem_ack),
    .count      (count)
  );

  typedef struct {
    logic        stv;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [3:0]  sm;
    logic        ldv;
    logic [31:0] la;
    logic        fence;
    logic        ack;
    logic [2:0]  e_cnt;
    logic        e_req;
    logic        e_rdy;
    logic        e_conf;
    logic        e_fd;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   nchk  = 0;
  int   npass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic stv, input logic [31:0] sa, input logic [31:0] sd,
                              input logic [3:0] sm, input logic ldv, input logic [31:0] la,
                              input logic fence, input logic ack, input logic [2:0] e_cnt,
                              input logic e_req, input logic e_rdy, input logic e_conf,
                              input logic e_fd);
    vec_t v;
    v.stv = stv; v.sa = sa; v.sd = sd; v.sm = sm; v.ldv = ldv; v.la = la;
    v.fence = fence; v.ack = ack; v.e_cnt = e_cnt; v.e_req = e_req; v.e_rdy = e_rdy;
    v.e_conf = e_conf; v.e_fd = e_fd;
    return v;
  endfunction

  task automatic drive(input logic stv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [3:0] sm, input logic ldv, input logic [31:0] la,
                       input logic fence, input logic ack);
    st_valid = stv; st_addr = sa; st_data = sd; st_mask = sm;
    ld_valid = ldv; ld_addr = la; fence_req = fence; mem_ack = ack;
  endtask

  task automatic run_row(input int i);
    vec_t v;
    sb_t  e;
    v = vecs[i];
    @(negedge clk);
    drive(v.stv, v.sa, v.sd, v.sm, v.ldv, v.la, v.fence, v.ack);
    #1;
    chk($sformatf("r%0d count", i), 32'(count), 32'(v.e_cnt));
    chk($sformatf("r%0d mem_req", i), 32'(mem_req), 32'(v.e_req));
    chk($sformatf("r%0d st_ready", i), 32'(st_ready), 32'(v.e_rdy));
    chk($sformatf("r%0d ld_conflict", i), 32'(ld_conflict), 32'(v.e_conf));
    chk($sformatf("r%0d fence_done", i), 32'(fence_done), 32'(v.e_fd));
    if (v.e_req) begin
      if (sbq.size() == 0) begin
        nchk++;
        $display("FAIL r%0d scoreboard: mem_req=%0b but no store expected", i, mem_req);
      end else begin
        e = sbq[0];
        chk($sformatf("r%0d mem_addr", i), mem_addr, e.addr);
        chk($sformatf("r%0d mem_data", i), mem_data, e.data);
        chk($sformatf("r%0d mem_mask", i), 32'(mem_mask), 32'(e.mask));
        if (v.ack) void'(sbq.pop_front());
      end
    end else begin
      chk($sformatf("r%0d idle mem_addr", i), mem_addr, 32'h0);
      chk($sformatf("r%0d idle mem_mask", i), 32'(mem_mask), 32'h0);
    end
    if (v.stv && v.e_rdy) begin
      e.addr = {v.sa[31:2], 2'b00};
      e.data = v.sd;
      e.mask = v.sm;
      sbq.push_back(e);
    end
  endtask

  // Drive one idle cycle (optionally acking) and check the head presented to memory.
  task automatic expect_head(input string name, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] m, input logic ack);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, ack);
    #1;
    chk({name, " req"}, 32'(mem_req), 32'h1);
    chk({name, " addr"}, mem_addr, a);
    chk({name, " data"}, mem_data, d);
    chk({name, " mask"}, 32'(mem_mask), 32'(m));
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    drive(1'b1, a, d, m, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic expect_count(input string name, input logic [2:0] c);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk(name, 32'(count), 32'(c));
  endtask

  initial begin
    // stv sa sd sm ldv la fence ack | cnt req rdy conf fd
    vecs.push_back(mk(1, 32'h100, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 32'h000, 32'h11111111, 4'hF, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 32'h004, 32'h22222222, 4'hF, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h008, 32'h33333333, 4'hF, 0, 0, 0, 0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h00C, 32'h44444444, 4'hF, 0, 0, 0, 0, 3, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h010, 32'h55555555, 4'hF, 0, 0, 0, 0, 4, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h010, 32'h55555555, 4'hF, 0, 0, 0, 1, 4, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h010, 32'h55555555, 4'hF, 0, 0, 0, 0, 3, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 32'h204, 32'h00CC0000, 4'h4, 1, 32'h206, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h206, 0, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h208, 0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h206, 0, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h206, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 32'h400, 32'hA0A0A0A0, 4'hF, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 32'h404, 32'hB1B1B1B1, 4'h3, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h408, 32'hC2C2C2C2, 4'hC, 0, 0, 0, 1, 2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 32'h500, 32'h50505050, 4'hF, 0, 0, 1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 32'h504, 32'h51515151, 4'hF, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h508, 32'h52525252, 4'hF, 0, 0, 0, 0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 3, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1));

    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    #1;
    chk("reset st_ready", 32'(st_ready), 32'h1);
    chk("reset mem_req", 32'(mem_req), 32'h0);
    chk("reset count", 32'(count), 32'h0);
    chk("reset ld_conflict", 32'(ld_conflict), 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_row(i);

    // Reset while two entries are pending and the head is being acked.
    store(32'h600, 32'h60606060, 4'hF);
    store(32'h604, 32'h61616161, 4'hF);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("pre-reset count", 32'(count), 32'h2);
    #1;
    reset = 1'b1;
    #1;
    chk("mid-drain reset mem_req", 32'(mem_req), 32'h0);
    chk("mid-drain reset count", 32'(count), 32'h0);
    chk("mid-drain reset mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    store(32'h700, 32'h77777777, 4'hF);
    expect_head("post-reset head", 32'h700, 32'h77777777, 4'hF, 1'b1);
    expect_count("post-reset drained", 3'd0);

    // Same-word store onto the tail entry with two entries buffered.
    store(32'h300, 32'h12345678, 4'hF);
    store(32'h310, 32'h000000EE, 4'h1);
    store(32'h312, 32'h00DD0000, 4'h4);
    #1;
    chk("merge st_ready", 32'(st_ready), 32'h1);
`ifdef STORE_MERGE_EN
    expect_count("merge count", 3'd2);
    expect_head("merge head", 32'h300, 32'h12345678, 4'hF, 1'b1);
    expect_head("merged entry", 32'h310, 32'h00DD00EE, 4'h5, 1'b1);
`else
    expect_count("no-merge count", 3'd3);
    expect_head("no-merge head", 32'h300, 32'h12345678, 4'hF, 1'b1);
    expect_head("no-merge e1", 32'h310, 32'h000000EE, 4'h1, 1'b1);
    expect_head("no-merge e2", 32'h310, 32'h00DD0000, 4'h4, 1'b1);
`endif
    expect_count("merge drained", 3'd0);

    // With a single entry the head is in flight, so a same-word store allocates.
    store(32'h310, 32'h000000EE, 4'h1);
    store(32'h312, 32'h00DD0000, 4'h4);
    expect_count("count1 alloc", 3'd2);
    expect_head("count1 e0", 32'h310, 32'h000000EE, 4'h1, 1'b1);
    expect_head("count1 e1", 32'h310, 32'h00DD0000, 4'h4, 1'b1);
    expect_count("count1 drained", 3'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
